// File: rtl/fp_compare_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cmp_pkg
//  Description : Shared types for the pipelined IEEE-754 compare / min-max
//                unit: opcode encoding, per-operand classification record and
//                a helper that builds the canonical quiet NaN for any format.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_cmp_pkg;

    // Opcodes 5..7 are reserved and decoded as "invalid operation".
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_LT  = 3'd1,
        CMP_LE  = 3'd2,
        CMP_MIN = 3'd3,
        CMP_MAX = 3'd4
    } cmp_op_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic sign;
    } fp_class_t;

    localparam int CANON_MAX_W = 128;

    // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
    // Returned right-aligned in a wide vector; callers size-cast to W.
    function automatic logic [CANON_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [CANON_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CANON_MAX_W; i++) begin
            if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage : fp_cmp_pkg
`default_nettype wire

// File: rtl/fp_compare_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_compare_pipe_if
//  Description : Operand/result bundle of the compare unit. Input side is a
//                valid/ready beat carrying two operands, an opcode and a tag;
//                output side is a valid/ready beat carrying flags and values.
//  Ports       : slave  - view taken by the compare unit
//                master - view taken by the issue stage / writeback consumer
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_compare_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_lt;
    logic             out_eq;
    logic             out_gt;
    logic             out_uo;
    logic             out_res;
    logic [W-1:0]     out_val;
    logic             out_inv;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_lt, out_eq, out_gt, out_uo,
               out_res, out_val, out_inv, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_lt, out_eq, out_gt, out_uo,
               out_res, out_val, out_inv, out_tag
    );

endinterface : fp_compare_pipe_if
`default_nettype wire

// File: rtl/fp_compare_pipe_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational classification of one IEEE-754 operand into
//                zero / infinity / quiet NaN / signalling NaN plus its sign.
//                Normals and subnormals leave all class bits clear.
//  Ports       : op_i  [EXP_W+MAN_W:0]  operand
//                cls_o fp_class_t       classification
//  Revision    : 1.0  initial release
// ============================================================================
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire logic [EXP_W+MAN_W:0] op_i,
    output fp_class_t                 cls_o
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;

    assign w_exp      = op_i[MAN_W +: EXP_W];
    assign w_man      = op_i[MAN_W-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_zero = ~|w_man;

    always_comb begin
        cls_o      = '0;
        cls_o.sign = op_i[EXP_W+MAN_W];
        cls_o.zero = w_exp_zero & w_man_zero;
        cls_o.inf  = w_exp_ones & w_man_zero;
        // Mantissa MSB is the quiet bit.
        cls_o.qnan = w_exp_ones & w_man[MAN_W-1];
        cls_o.snan = w_exp_ones & ~w_man_zero & ~w_man[MAN_W-1];
    end

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_compare_pipe
//  Description : Two-stage pipelined IEEE-754 comparator and min/max unit.
//                Stage 1 classifies both operands and compares magnitudes;
//                stage 2 resolves ordering, predicate, min/max and the
//                invalid flag into the output registers.
//  Ports       : clk    clock
//                rst_n  synchronous reset, active low
//                bus    fp_compare_pipe_if.slave (operand in / result out)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fp_compare_pipe_if.slave bus
);

    localparam int            W      = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0]  C_QNAN = W'(canon_qnan(EXP_W, MAN_W));

    // ------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------
    logic w_s1_load;
    logic w_s2_load;
    logic w_accept;

    logic s1_valid_q;
    logic out_valid_q;

    assign w_s2_load    = ~out_valid_q | bus.out_ready;
    assign w_s1_load    = ~s1_valid_q  | w_s2_load;
    assign bus.in_ready = w_s1_load;
    assign w_accept     = bus.in_valid & w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: classify + magnitude compare
    // ------------------------------------------------------------------
    fp_class_t w_cls_a;
    fp_class_t w_cls_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op_i(bus.in_a), .cls_o(w_cls_a));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op_i(bus.in_b), .cls_o(w_cls_b));

    logic [W-2:0] w_mag_a;
    logic [W-2:0] w_mag_b;
    logic         w_mag_gt_d;
    logic         w_mag_eq_d;

    assign w_mag_a = bus.in_a[W-2:0];
    assign w_mag_b = bus.in_b[W-2:0];

    // Infinities short-circuit the magnitude compare; NaN lanes are masked
    // in stage 2, so their magnitude result is don't-care.
    always_comb begin
        w_mag_gt_d = 1'b0;
        w_mag_eq_d = 1'b0;
        if (w_cls_a.inf || w_cls_b.inf) begin
            w_mag_gt_d = w_cls_a.inf & ~w_cls_b.inf;
            w_mag_eq_d = w_cls_a.inf &  w_cls_b.inf;
        end else begin
            w_mag_gt_d = (w_mag_a >  w_mag_b);
            w_mag_eq_d = (w_mag_a == w_mag_b);
        end
    end

    logic [W-1:0]     s1_a_q,  s1_b_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_nan_a_q,  s1_nan_b_q;
    logic             s1_snan_a_q, s1_snan_b_q;
    logic             s1_zero_a_q, s1_zero_b_q;
    logic             s1_sign_a_q, s1_sign_b_q;
    logic             s1_mag_gt_q, s1_mag_eq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            s1_nan_a_q  <= 1'b0;
            s1_nan_b_q  <= 1'b0;
            s1_snan_a_q <= 1'b0;
            s1_snan_b_q <= 1'b0;
            s1_zero_a_q <= 1'b0;
            s1_zero_b_q <= 1'b0;
            s1_sign_a_q <= 1'b0;
            s1_sign_b_q <= 1'b0;
            s1_mag_gt_q <= 1'b0;
            s1_mag_eq_q <= 1'b0;
        end else begin
            if (w_s1_load) begin
                s1_valid_q <= bus.in_valid;
            end
            if (w_accept) begin
                s1_a_q      <= bus.in_a;
                s1_b_q      <= bus.in_b;
                s1_op_q     <= bus.in_op;
                s1_tag_q    <= bus.in_tag;
                s1_nan_a_q  <= w_cls_a.qnan | w_cls_a.snan;
                s1_nan_b_q  <= w_cls_b.qnan | w_cls_b.snan;
                s1_snan_a_q <= w_cls_a.snan;
                s1_snan_b_q <= w_cls_b.snan;
                s1_zero_a_q <= w_cls_a.zero;
                s1_zero_b_q <= w_cls_b.zero;
                s1_sign_a_q <= w_cls_a.sign;
                s1_sign_b_q <= w_cls_b.sign;
                s1_mag_gt_q <= w_mag_gt_d;
                s1_mag_eq_q <= w_mag_eq_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: resolve ordering, predicate, min/max, invalid
    // ------------------------------------------------------------------
    logic         w_lt_d, w_eq_d, w_gt_d, w_uo_d;
    logic         w_res_d;
    logic [W-1:0] w_val_d;
    logic         w_inv_d;
    logic         w_both_zero;
    logic         w_snan_any;
    logic         w_is_max;
    logic [W-1:0] w_minmax;

    assign w_both_zero = s1_zero_a_q & s1_zero_b_q;
    assign w_snan_any  = s1_snan_a_q | s1_snan_b_q;
    assign w_is_max    = (s1_op_q == CMP_MAX);

    always_comb begin
        w_lt_d = 1'b0;
        w_eq_d = 1'b0;
        w_gt_d = 1'b0;
        w_uo_d = 1'b0;
        if (s1_nan_a_q || s1_nan_b_q) begin
            w_uo_d = 1'b1;
        end else if (w_both_zero) begin
            w_eq_d = 1'b1;
        end else if (s1_sign_a_q != s1_sign_b_q) begin
            w_lt_d = s1_sign_a_q;
            w_gt_d = s1_sign_b_q;
        end else if (s1_mag_eq_q) begin
            w_eq_d = 1'b1;
        end else if (s1_mag_gt_q ^ s1_sign_a_q) begin
            // Larger magnitude is the greater value only when positive.
            w_gt_d = 1'b1;
        end else begin
            w_lt_d = 1'b1;
        end
    end

    always_comb begin
        w_minmax = s1_a_q;
        if (s1_nan_a_q && s1_nan_b_q) begin
            w_minmax = C_QNAN;
        end else if (s1_nan_a_q) begin
            w_minmax = s1_b_q;
        end else if (s1_nan_b_q) begin
            w_minmax = s1_a_q;
        end else if (w_eq_d) begin
            // Signed zeros: min picks the negative one, max the positive one.
            if (w_both_zero && (s1_sign_a_q != s1_sign_b_q)) begin
                w_minmax = (s1_sign_a_q ^ w_is_max) ? s1_a_q : s1_b_q;
            end else begin
                w_minmax = s1_a_q;
            end
        end else if (w_is_max) begin
            w_minmax = w_gt_d ? s1_a_q : s1_b_q;
        end else begin
            w_minmax = w_lt_d ? s1_a_q : s1_b_q;
        end
    end

    always_comb begin
        w_res_d = 1'b0;
        w_val_d = '0;
        w_inv_d = 1'b1;
        case (cmp_op_e'(s1_op_q))
            CMP_EQ: begin
                w_res_d = w_eq_d;
                w_inv_d = w_snan_any;
            end
            CMP_LT: begin
                w_res_d = w_lt_d;
                w_inv_d = w_uo_d;
            end
            CMP_LE: begin
                w_res_d = w_lt_d | w_eq_d;
                w_inv_d = w_uo_d;
            end
            CMP_MIN, CMP_MAX: begin
                w_val_d = w_minmax;
                w_inv_d = w_snan_any;
            end
            default: begin
                w_inv_d = 1'b1;
            end
        endcase
    end

    logic             out_lt_q, out_eq_q, out_gt_q, out_uo_q;
    logic             out_res_q;
    logic [W-1:0]     out_val_q;
    logic             out_inv_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_lt_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_gt_q    <= 1'b0;
            out_uo_q    <= 1'b0;
            out_res_q   <= 1'b0;
            out_val_q   <= '0;
            out_inv_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (w_s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_lt_q  <= w_lt_d;
                out_eq_q  <= w_eq_d;
                out_gt_q  <= w_gt_d;
                out_uo_q  <= w_uo_d;
                out_res_q <= w_res_d;
                out_val_q <= w_val_d;
                out_inv_q <= w_inv_d;
                out_tag_q <= s1_tag_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_lt    = out_lt_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_gt    = out_gt_q;
    assign bus.out_uo    = out_uo_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_inv   = out_inv_q;
    assign bus.out_tag   = out_tag_q;

endmodule : fp_compare_pipe
`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_compare_pipe
//  Description : Self-checking bench for fp_compare_pipe (binary32). A
//                value-level reference model (operands mapped to signed
//                ordering keys) feeds a scoreboard checked every cycle;
//                directed vectors carry hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_compare_pipe;

    logic clk;
    logic rst_n;

    fp_compare_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each non-NaN operand becomes a signed integer key
    // (+/-magnitude), so IEEE ordering is plain integer ordering and both
    // zeros share key 0.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        lt, eq, gt, uo, res;
        logic [31:0] val;
        logic        inv;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint ma, mb, ka, kb;
        logic   na, nb, sa, sb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sa = na && !a[22];
        sb = nb && !b[22];
        ma = a[30:0];
        mb = b[30:0];
        ka = a[31] ? -ma : ma;
        kb = b[31] ? -mb : mb;
        e = '0;
        e.uo = na | nb;
        if (!e.uo) begin
            e.lt = ka < kb;
            e.eq = ka == kb;
            e.gt = ka > kb;
        end
        case (op)
            3'd0: begin e.res = e.eq;        e.inv = sa | sb; end
            3'd1: begin e.res = e.lt;        e.inv = e.uo;    end
            3'd2: begin e.res = e.lt | e.eq; e.inv = e.uo;    end
            3'd3, 3'd4: begin
                e.inv = sa | sb;
                if (na && nb)      e.val = 32'h7FC0_0000;
                else if (na)       e.val = b;
                else if (nb)       e.val = a;
                else if (ka == kb) begin
                    if (ma == 0 && a[31] != b[31])
                        e.val = (op == 3'd3) ? (a[31] ? a : b) : (a[31] ? b : a);
                    else
                        e.val = a;
                end
                else if (op == 3'd3) e.val = (ka < kb) ? a : b;
                else                 e.val = (ka > kb) ? a : b;
            end
            default: e.inv = 1'b1;
        endcase
        return e;
    endfunction

    typedef struct {
        int         t;
        exp_t       e;
        logic [3:0] tag;
    } sb_t;

    sb_t        q[$];
    logic [3:0] emitted[$];
    int         cyc = 0;
    logic       saw_stall = 1'b0;

    // Scoreboard monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("out_valid", bus.out_valid, (q.size() > 0) && (cyc - q[0].t >= 2));
            chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.out_valid && q.size() > 0) begin
                chk("mon_tag", bus.out_tag, q[0].tag);
                chk("mon_lt",  bus.out_lt,  q[0].e.lt);
                chk("mon_eq",  bus.out_eq,  q[0].e.eq);
                chk("mon_gt",  bus.out_gt,  q[0].e.gt);
                chk("mon_uo",  bus.out_uo,  q[0].e.uo);
                chk("mon_res", bus.out_res, q[0].e.res);
                chk("mon_val", bus.out_val, q[0].e.val);
                chk("mon_inv", bus.out_inv, q[0].e.inv);
                if (bus.out_ready) begin
                    emitted.push_back(bus.out_tag);
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{t: cyc, e: model(bus.in_op, bus.in_a, bus.in_b), tag: bus.in_tag});
            end
        end
    end

    // Single beat on an empty pipe with out_ready=1; checks 2-cycle latency
    // and the hand-computed result.
    task automatic run_lit(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic lt, input logic eq, input logic gt, input logic uo,
                           input logic res, input logic [31:0] val, input logic inv);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = 4'h7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({nm, "_early"}, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, bus.out_valid, 1'b1);
        chk({nm, "_lt"},  bus.out_lt,  lt);
        chk({nm, "_eq"},  bus.out_eq,  eq);
        chk({nm, "_gt"},  bus.out_gt,  gt);
        chk({nm, "_uo"},  bus.out_uo,  uo);
        chk({nm, "_res"}, bus.out_res, res);
        chk({nm, "_val"}, bus.out_val, val);
        chk({nm, "_inv"}, bus.out_inv, inv);
    endtask

    task automatic send_beat(input logic [3:0] tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_tag   = tag;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_val",   bus.out_val,   32'h0);
        chk("rst_out_tag",   bus.out_tag,   4'h0);
        chk("rst_out_flags", {bus.out_lt, bus.out_eq, bus.out_gt, bus.out_uo, bus.out_res, bus.out_inv}, 6'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        //        name    op     a             b             lt eq gt uo res val           inv
        run_lit("t1a", 3'd1, 32'h3F800000, 32'h40000000, 1, 0, 0, 0, 1, 32'h00000000, 0);
        run_lit("t1b", 3'd1, 32'hC0000000, 32'hBF800000, 1, 0, 0, 0, 1, 32'h00000000, 0);
        run_lit("t2a", 3'd0, 32'h80000000, 32'h00000000, 0, 1, 0, 0, 1, 32'h00000000, 0);
        run_lit("t2b", 3'd3, 32'h80000000, 32'h00000000, 0, 1, 0, 0, 0, 32'h80000000, 0);
        run_lit("t2c", 3'd4, 32'h00000000, 32'h80000000, 0, 1, 0, 0, 0, 32'h00000000, 0);
        run_lit("t2d", 3'd4, 32'h80000000, 32'h00000000, 0, 1, 0, 0, 0, 32'h00000000, 0);
        run_lit("t3a", 3'd1, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h00000000, 1);
        run_lit("t3b", 3'd0, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h00000000, 0);
        run_lit("t4a", 3'd4, 32'h7F800001, 32'h3F800000, 0, 0, 0, 1, 0, 32'h3F800000, 1);
        run_lit("t4b", 3'd3, 32'h7FC00000, 32'hFFC00001, 0, 0, 0, 1, 0, 32'h7FC00000, 0);
        run_lit("sub", 3'd1, 32'h00000001, 32'h00000002, 1, 0, 0, 0, 1, 32'h00000000, 0);
        run_lit("inf", 3'd2, 32'hFF800000, 32'h7F800000, 1, 0, 0, 0, 1, 32'h00000000, 0);
        run_lit("rsv", 3'd5, 32'h3F800000, 32'h3F800000, 0, 1, 0, 0, 0, 32'h00000000, 1);
        run_lit("mxn", 3'd4, 32'hC0000000, 32'hBF800000, 1, 0, 0, 0, 0, 32'hBF800000, 0);
        run_lit("leq", 3'd2, 32'h40000000, 32'h40000000, 0, 1, 0, 0, 1, 32'h00000000, 0);
        run_lit("mns", 3'd3, 32'h00800000, 32'h007FFFFF, 0, 0, 1, 0, 0, 32'h007FFFFF, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 6 back-to-back beats, out_ready low in cycles 2..5.
        base      = emitted.size();
        saw_stall = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    send_beat(4'(t), 3'(t % 5), 32'h3F800000 + 32'(t), 32'h3F800003);
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 2 && c <= 5);
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_stall_seen", saw_stall, 1'b1);
        chk("bp_count", emitted.size() - base, 6);
        for (int i = 0; i < 6 && base + i < emitted.size(); i++) begin
            chk("bp_order", emitted[base + i], 4'(i));
        end

        // Reset with two beats in flight.
        base          = emitted.size();
        bus.out_ready = 1'b0;
        send_beat(4'hA, 3'd1, 32'h3F800000, 32'h40000000);
        send_beat(4'hB, 3'd0, 32'h3F800000, 32'h3F800000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_flush_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_emit", emitted.size() - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fp_compare_pipe
`default_nettype wire
